div_seq: RTL
============

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL have parameter DW, default 32, giving the operand width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the clock; every register updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port start_i, input, 1 bit: divide request from EX; held high until ready_o is seen.
REQ-005 The block SHALL have port annul_i, input, 1 bit: abort the operation in flight (flush).
REQ-006 The block SHALL have port signed_i, input, 1 bit: 1 selects a signed divide (div), 0 selects an unsigned divide (divu).
REQ-007 The block SHALL have port opdata1_i, input, DW bits: the dividend.
REQ-008 The block SHALL have port opdata2_i, input, DW bits: the divisor.
REQ-009 The block SHALL have port result_o, output, 2*DW bits: {remainder (HI), quotient (LO)}.
REQ-010 The block SHALL have port ready_o, output, 1 bit: result_o is valid.
REQ-011 The block SHALL have port stallreq_o, output, 1 bit: stall request into the pipeline stall bus.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, BYZERO, ON and END.
REQ-013 From IDLE the FSM SHALL transition as follows:
- start_i=1, annul_i=0, divisor=0: go to BYZERO.
- start_i=1, annul_i=0, divisor nonzero: go to ON.
- Otherwise: stay in IDLE.
REQ-014 On leaving IDLE for ON, the block SHALL latch the absolute values of both operands (two's-complement negation when signed_i=1 and the MSB is 1), the signs, and signed_i, and SHALL clear the iteration counter cnt.
REQ-015 In ON, while cnt<DW, the block SHALL perform one restoring shift-subtract step per cycle on a 2*DW+1-bit working register and SHALL increment cnt.
REQ-016 In ON, when cnt==DW, the block SHALL apply sign correction and go to END:
- quotient is negated if the signs differ (signed only);
- remainder takes the sign of the dividend.
REQ-017 In ON, annul_i=1 SHALL force the next state to IDLE with no result produced; annul_i SHALL have the same effect in BYZERO.
REQ-018 BYZERO SHALL load result_o=0 and go to END on the next cycle.
REQ-019 In END, ready_o SHALL be 1 and result_o SHALL hold stable; the FSM SHALL return to IDLE in the cycle after start_i is observed low, and ready_o SHALL be 0 from then on.
REQ-020 ready_o and result_o SHALL be registered; result_o SHALL keep its last value in IDLE.
REQ-021 stallreq_o SHALL be combinational and SHALL equal (IDLE & start_i & ~annul_i) | BYZERO | ON; it SHALL be 0 in END.
REQ-022 Latency for a nonzero divisor: ready_o SHALL rise exactly DW+2 cycles after start_i is first sampled in IDLE (34 for DW=32).
REQ-023 Latency for a zero divisor: ready_o SHALL rise exactly 2 cycles after start_i is first sampled in IDLE.
REQ-024 A signed divide of 0x80000000 by 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0 (wrap, no trap).
REQ-025 Changes to the operand inputs after the start sample SHALL NOT affect the result.

Reset
REQ-026 rst=1 SHALL force, at the next edge and from any state including mid-ON: state=IDLE, cnt=0, result_o=0, ready_o=0.
REQ-027 stallreq_o SHALL be 0 during reset unless start_i is high.

Structure
REQ-028 The shared defines package SHALL hold the FSM state encodings (2 bits) and the DW default; the block SHALL be one module with no sub-modules.
REQ-029 The block SHALL instantiate a single DW+1-bit subtractor; the EX stage SHALL OR stallreq_o into its stall request to the existing ctrl unit.

Verification
REQ-030 Unsigned 100/7 -> ready_o high at cycle 34, result_o = {32'd2, 32'd14}, stallreq_o high in cycles 0..33.
REQ-031 Signed -7/2 (0xFFFFFFF9, 2) -> result_o = {0xFFFFFFFF, 0xFFFFFFFD}; signed 7/-2 -> {0x00000001, 0xFFFFFFFD}.
REQ-032 Divisor 0, any dividend -> ready_o at cycle 2, result_o = 0.
REQ-033 annul_i pulsed at cycle 10 of ON -> IDLE next cycle, ready_o never rises, and stallreq_o is 0 once start_i drops; a fresh 100/7 then completes correctly.
REQ-034 rst asserted at cycle 20 of ON -> IDLE, result_o=0, ready_o=0 on the next edge.
REQ-035 start_i held high for 3 cycles in END -> result_o stable, ready_o=1 throughout, IDLE one cycle after start_i falls; signed 0x80000000/-1 -> {0, 0x80000000}.

Source files
------------

// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential divider: state encodings and the default width.
package div_seq_pkg;

    localparam int DIV_DW_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_BYZERO = 2'b01,
        ST_ON     = 2'b10,
        ST_END    = 2'b11
    } div_state_e;

endpackage

// File: rtl/div_seq.sv
// Sequential radix-2 restoring divider (div/divu) for the EX stage.
// Produces {remainder, quotient}; stallreq_o holds the pipeline while a divide runs.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DW = DIV_DW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            annul_i,
    input  logic            signed_i,
    input  logic [DW-1:0]   opdata1_i,
    input  logic [DW-1:0]   opdata2_i,
    output logic [2*DW-1:0] result_o,
    output logic            ready_o,
    output logic            stallreq_o
);

    localparam int CW = $clog2(DW + 1);

    div_state_e      r_state;
    div_state_e      w_next;
    logic [CW-1:0]   r_cnt;
    logic [2*DW:0]   r_work;
    logic [DW-1:0]   r_divisor;
    logic            r_sign1;
    logic            r_sign2;
    logic            r_signed;
    logic [2*DW-1:0] r_result;
    logic            r_ready;

    logic [DW-1:0]   w_abs1;
    logic [DW-1:0]   w_abs2;
    logic [DW:0]     w_diff;
    logic [DW-1:0]   w_quot;
    logic [DW-1:0]   w_rem;
    logic [DW-1:0]   w_quot_fix;
    logic [DW-1:0]   w_rem_fix;
    logic            w_cnt_done;

    assign w_abs1 = (signed_i && opdata1_i[DW-1]) ? (~opdata1_i + DW'(1)) : opdata1_i;
    assign w_abs2 = (signed_i && opdata2_i[DW-1]) ? (~opdata2_i + DW'(1)) : opdata2_i;

    // Working register layout: [2DW:DW+1] partial remainder, [DW:1] dividend/quotient bits.
    assign w_diff     = {1'b0, r_work[2*DW-1:DW]} - {1'b0, r_divisor};
    assign w_quot     = r_work[DW-1:0];
    assign w_rem      = r_work[2*DW:DW+1];
    assign w_quot_fix = (r_signed && (r_sign1 ^ r_sign2)) ? (~w_quot + DW'(1)) : w_quot;
    assign w_rem_fix  = (r_signed && r_sign1) ? (~w_rem + DW'(1)) : w_rem;
    assign w_cnt_done = (r_cnt == CW'(DW));

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_i && !annul_i) begin
                    w_next = (opdata2_i == '0) ? ST_BYZERO : ST_ON;
                end
            end
            ST_BYZERO: w_next = annul_i ? ST_IDLE : ST_END;
            ST_ON: begin
                if (annul_i) begin
                    w_next = ST_IDLE;
                end else if (w_cnt_done) begin
                    w_next = ST_END;
                end
            end
            ST_END: begin
                if (!start_i) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Reset may land mid-divide while the state register still reads ON.
    always_comb begin
        if (rst) begin
            stallreq_o = start_i && !annul_i;
        end else begin
            stallreq_o = ((r_state == ST_IDLE) && start_i && !annul_i) ||
                         (r_state == ST_BYZERO) || (r_state == ST_ON);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_work    <= '0;
            r_divisor <= '0;
            r_sign1   <= 1'b0;
            r_sign2   <= 1'b0;
            r_signed  <= 1'b0;
            r_result  <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b0;
                    if (w_next == ST_ON) begin
                        r_work    <= {{DW{1'b0}}, w_abs1, 1'b0};
                        r_divisor <= w_abs2;
                        r_sign1   <= opdata1_i[DW-1];
                        r_sign2   <= opdata2_i[DW-1];
                        r_signed  <= signed_i;
                        r_cnt     <= '0;
                    end
                end
                ST_BYZERO: begin
                    if (!annul_i) begin
                        r_result <= '0;
                        r_ready  <= 1'b1;
                    end
                end
                ST_ON: begin
                    if (!annul_i) begin
                        if (!w_cnt_done) begin
                            // Borrow means the trial subtract failed: shift in a 0 quotient bit.
                            if (w_diff[DW]) begin
                                r_work <= {r_work[2*DW-1:0], 1'b0};
                            end else begin
                                r_work <= {w_diff[DW-1:0], r_work[DW-1:0], 1'b1};
                            end
                            r_cnt <= r_cnt + CW'(1);
                        end else begin
                            r_result <= {w_rem_fix, w_quot_fix};
                            r_ready  <= 1'b1;
                        end
                    end
                end
                ST_END: begin
                    if (!start_i) begin
                        r_ready <= 1'b0;
                    end
                end
                default: r_ready <= 1'b0;
            endcase
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule
